pcr_rd_req_arbiter: RTL

- Shares the single DDR read-command port among the per-program read requests raised by the PCR interval adaptation stage.
- Request vector: TOTAL_PROG_NUM bits, 16 channels × PROG_PER_CHAN programs.
- Two-level round-robin (channel, then program within channel), credit-limited by outstanding reads.
- Returns a one-cycle ack to the winning requester; sits between the PCR interval adaptation stage and the DDR read controller.

---
 rtl/pcr_arb_pkg.sv | 36 +++
 rtl/pcr_rd_req_arbiter_rr_pick16.sv | 30 +++
 rtl/pcr_rd_req_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pcr_arb_pkg.sv
// Shared constants for the PCR read-request arbiter.
// State encoding, channel geometry and index helpers.
package pcr_arb_pkg;

    localparam int NUM_CHN       = 16;
    localparam int CHN_BIT       = 4;
    localparam int MAX_OUT_LIMIT = 15;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARB   = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    localparam logic [1:0] ST_ACK   = 2'd3;

    // Flat requester index of program 0 in a channel ({chn,prog} layout).
    function automatic int unsigned chn_base(
        input int unsigned chn,
        input int unsigned prog_bits
    );
        return chn << prog_bits;
    endfunction

    function automatic int unsigned prog_of(
        input int unsigned idx,
        input int unsigned prog_bits
    );
        return idx & ((32'd1 << prog_bits) - 32'd1);
    endfunction

    // Credit depth must fit the 4-bit outstanding counter.
    function automatic int clamp_outstanding(input int n);
        if (n < 1) return 1;
        if (n > MAX_OUT_LIMIT) return MAX_OUT_LIMIT;
        return n;
    endfunction

endpackage

// File: rtl/pcr_rd_req_arbiter_rr_pick16.sv
// Combinational round-robin picker: first set request at or after pointer.
// Default width is 16 inputs; IDX_W generalises it to 2**IDX_W inputs.
module rr_pick16 #(
    parameter int IDX_W = 4
) (
    input  logic [(1<<IDX_W)-1:0] request,
    input  logic [IDX_W-1:0]      pointer,
    output logic                  found,
    output logic [IDX_W-1:0]      index
);

    localparam int N = 1 << IDX_W;

    logic [IDX_W-1:0] cand;

    // Scan from the far end so the nearest hit after the pointer wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = pointer + k[IDX_W-1:0];
            if (request[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/pcr_rd_req_arbiter.sv
// Two-level round-robin, credit-limited DDR read-command arbiter.
// Optional starvation monitor: define PCR_ARB_STARVE_MON_EN.
module pcr_rd_req_arbiter
    import pcr_arb_pkg::*;
#(
    parameter int PROG_BIT_WIDTH   = 8,
    parameter int TOTAL_PROG_NUM   = 2**PROG_BIT_WIDTH,
    parameter int PROG_PER_CHN_BIT = PROG_BIT_WIDTH - 4,
    parameter int MAX_OUTSTANDING  = 4,
    parameter int STARVE_LIMIT     = 4096
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [15:0]                 chn_enable,
    input  logic [TOTAL_PROG_NUM-1:0]   ddr_rd_data_req,
    output logic [TOTAL_PROG_NUM-1:0]   ddr_rd_data_ack,
    output logic                        rd_cmd_valid,
    input  logic                        rd_cmd_ready,
    output logic [3:0]                  rd_cmd_chn,
    output logic [PROG_PER_CHN_BIT-1:0] rd_cmd_prog,
    input  logic                        rd_done,
    output logic [3:0]                  outstanding_cnt,
    output logic                        done_underflow,
    output logic                        starve_err,
    output logic [3:0]                  starve_chn
);

    localparam int PB  = PROG_PER_CHN_BIT;
    localparam int PPC = 1 << PB;
    localparam logic [3:0] MAX_OUT = 4'(clamp_outstanding(MAX_OUTSTANDING));

    logic [TOTAL_PROG_NUM-1:0] eff_req;
    logic [NUM_CHN-1:0]        chn_req;

    for (genvar c = 0; c < NUM_CHN; c++) begin : g_mask
        localparam int B = int'(chn_base(c, PB));
        assign eff_req[B +: PPC] =
            ddr_rd_data_req[B +: PPC] & {PPC{chn_enable[c]}};
        assign chn_req[c] = |eff_req[B +: PPC];
    end

    logic [1:0]                  state_q, state_d;
    logic [3:0]                  chn_q, chn_d;
    logic [PB-1:0]               prog_q, prog_d;
    logic [3:0]                  chn_ptr_q, chn_ptr_d;
    logic [NUM_CHN-1:0][PB-1:0]  prog_ptr_q, prog_ptr_d;
    logic [3:0]                  cnt_q, cnt_d;
    logic                        under_q, under_d;

    logic          chn_found;
    logic [3:0]    chn_win;
    logic          prog_found;
    logic [PB-1:0] prog_win;
    logic [PPC-1:0] prog_req;
    logic [PB-1:0] prog_ptr;

    rr_pick16 #(.IDX_W(CHN_BIT)) u_chn_pick (
        .request (chn_req),
        .pointer (chn_ptr_q),
        .found   (chn_found),
        .index   (chn_win)
    );

    always_comb begin
        prog_req = '0;
        prog_ptr = '0;
        for (int c = 0; c < NUM_CHN; c++) begin
            if (chn_win == 4'(c)) begin
                prog_req = eff_req[c*PPC +: PPC];
                prog_ptr = prog_ptr_q[c];
            end
        end
    end

    rr_pick16 #(.IDX_W(PB)) u_prog_pick (
        .request (prog_req),
        .pointer (prog_ptr),
        .found   (prog_found),
        .index   (prog_win)
    );

    logic issue_fire;
    logic credit_ok;

    assign issue_fire = (state_q == ST_ISSUE) && rd_cmd_ready;
    // A completion in the same cycle frees a slot for the next arbitration.
    assign credit_ok  = (cnt_q < MAX_OUT) || rd_done;

    always_comb begin
        state_d    = state_q;
        chn_d      = chn_q;
        prog_d     = prog_q;
        chn_ptr_d  = chn_ptr_q;
        prog_ptr_d = prog_ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if ((|chn_req) && credit_ok) state_d = ST_ARB;
            end
            ST_ARB: begin
                if (chn_found && prog_found) begin
                    state_d = ST_ISSUE;
                    chn_d   = chn_win;
                    prog_d  = prog_win;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (rd_cmd_ready) begin
                    state_d           = ST_ACK;
                    chn_ptr_d         = chn_q + 4'd1;
                    prog_ptr_d[chn_q] = prog_q + 1'b1;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        under_d = under_q;
        if (issue_fire && !rd_done) begin
            cnt_d = cnt_q + 4'd1;
        end else if (!issue_fire && rd_done) begin
            if (cnt_q == 4'd0) under_d = 1'b1;
            else cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            chn_q      <= '0;
            prog_q     <= '0;
            chn_ptr_q  <= '0;
            prog_ptr_q <= '0;
            cnt_q      <= '0;
            under_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            chn_q      <= chn_d;
            prog_q     <= prog_d;
            chn_ptr_q  <= chn_ptr_d;
            prog_ptr_q <= prog_ptr_d;
            cnt_q      <= cnt_d;
            under_q    <= under_d;
        end
    end

    logic                      ack_st;
    logic [PROG_BIT_WIDTH-1:0] win_idx;

    assign ack_st  = (state_q == ST_ACK);
    assign win_idx = {chn_q, prog_q};

    assign ddr_rd_data_ack = ack_st ?
        (TOTAL_PROG_NUM'(1) << win_idx) : '0;
    assign rd_cmd_valid    = (state_q == ST_ISSUE);
    assign rd_cmd_chn      = chn_q;
    assign rd_cmd_prog     = prog_q;
    assign outstanding_cnt = cnt_q;
    assign done_underflow  = under_q;

`ifdef PCR_ARB_STARVE_MON_EN
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(STARVE_LIMIT);

    logic [NUM_CHN-1:0][WAIT_W-1:0] wait_q, wait_d;
    logic                           serr_q, serr_d;
    logic [3:0]                     schn_q, schn_d;

    // Descending scan leaves the lowest saturated channel in schn_d.
    always_comb begin
        wait_d = wait_q;
        serr_d = serr_q;
        schn_d = schn_q;
        for (int c = NUM_CHN - 1; c >= 0; c--) begin
            if (!chn_req[c] || (ack_st && chn_q == 4'(c)))
                wait_d[c] = '0;
            else if (wait_q[c] != LIMIT)
                wait_d[c] = wait_q[c] + 1'b1;
            if (!serr_q && wait_q[c] == LIMIT) begin
                serr_d = 1'b1;
                schn_d = 4'(c);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
            serr_q <= 1'b0;
            schn_q <= '0;
        end else begin
            wait_q <= wait_d;
            serr_q <= serr_d;
            schn_q <= schn_d;
        end
    end

    assign starve_err = serr_q;
    assign starve_chn = schn_q;
`else
    assign starve_err = 1'b0;
    assign starve_chn = 4'd0;
`endif

endmodule
